// File: rtl/output_vc_credit_tracker.sv
// Per-output-VC ownership and downstream credit tracker.
// Consumes allocator grants and switch-traversal events, and exposes
// registered availability/full/nearly-full masks plus sticky protocol errors.
module output_vc_credit_tracker #(
  parameter int unsigned P = 5,
  parameter int unsigned V = 4,
  parameter int unsigned B = 4,
  localparam int unsigned CW = $clog2(B + 1),
  localparam int unsigned N = P * V
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    ovc_allocated_all,
  input  logic [N-1:0]    flit_sent_all,
  input  logic [N-1:0]    tail_sent_all,
  input  logic [N-1:0]    credit_in_all,
  output logic [N-1:0]    ovc_status_all,
  output logic [N-1:0]    ovc_avail_all,
  output logic [N-1:0]    ovc_full_all,
  output logic [N-1:0]    ovc_nearly_full_all,
  output logic [P-1:0]    any_ovc_avail_all,
  output logic [N*CW-1:0] credit_cnt_all,
  output logic            err_credit_underflow,
  output logic            err_credit_overflow,
  output logic            err_double_alloc,
  output logic            err_send_unowned
);

  logic [CW-1:0] credit_q [N];
  logic [CW-1:0] credit_d [N];
  logic [N-1:0]  owned_q, owned_d;
  logic [N-1:0]  tail_eff;
  logic          ev_underflow, ev_overflow, ev_double, ev_unowned;
  logic          err_uf_q, err_of_q, err_da_q, err_su_q;

  // A tail only counts when a flit actually leaves.
  assign tail_eff = tail_sent_all & flit_sent_all;

  // Next-state for credit counters and ownership, plus per-cycle error events.
  always_comb begin
    owned_d      = owned_q;
    ev_underflow = 1'b0;
    ev_overflow  = 1'b0;
    ev_double    = 1'b0;
    ev_unowned   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      credit_d[i] = credit_q[i];
      if (flit_sent_all[i] && !credit_in_all[i]) begin
        if (credit_q[i] == '0) ev_underflow = 1'b1;
        else credit_d[i] = credit_q[i] - 1'b1;
      end else if (credit_in_all[i] && !flit_sent_all[i]) begin
        if (credit_q[i] == CW'(B)) ev_overflow = 1'b1;
        else credit_d[i] = credit_q[i] + 1'b1;
      end

      if (owned_q[i]) begin
        // Header on an owned OVC is illegal; a same-cycle tail still frees it.
        if (ovc_allocated_all[i]) ev_double = 1'b1;
        if (tail_eff[i]) owned_d[i] = 1'b0;
      end else begin
        // Single-flit packet allocated and sent together never becomes owned.
        if (ovc_allocated_all[i] && !tail_eff[i]) owned_d[i] = 1'b1;
        if (flit_sent_all[i] && !ovc_allocated_all[i]) ev_unowned = 1'b1;
      end
    end
  end

  // State registers; reset drops all ownership and refills every credit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N; i++) credit_q[i] <= CW'(B);
      owned_q  <= '0;
      err_uf_q <= 1'b0;
      err_of_q <= 1'b0;
      err_da_q <= 1'b0;
      err_su_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N; i++) credit_q[i] <= credit_d[i];
      owned_q  <= owned_d;
      err_uf_q <= err_uf_q | ev_underflow;
      err_of_q <= err_of_q | ev_overflow;
      err_da_q <= err_da_q | ev_double;
      err_su_q <= err_su_q | ev_unowned;
    end
  end

  // Moore decode of registered state into the per-VC masks.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      credit_cnt_all[i*CW +: CW] = credit_q[i];
      ovc_status_all[i]          = owned_q[i];
      ovc_full_all[i]            = (credit_q[i] == '0);
      ovc_nearly_full_all[i]     = (credit_q[i] == CW'(1));
      ovc_avail_all[i]           = !owned_q[i] && (credit_q[i] != '0);
    end
  end

  // Per-port summary of availability.
  always_comb begin
    for (int unsigned p = 0; p < P; p++) begin
      any_ovc_avail_all[p] = |ovc_avail_all[p*V +: V];
    end
  end

  assign err_credit_underflow = err_uf_q;
  assign err_credit_overflow  = err_of_q;
  assign err_double_alloc     = err_da_q;
  assign err_send_unowned     = err_su_q;

endmodule

// File: tb/tb_output_vc_credit_tracker.sv
// Directed and scoreboard-driven checks for output_vc_credit_tracker.
module tb_output_vc_credit_tracker;

  localparam int unsigned P  = 5;
  localparam int unsigned V  = 4;
  localparam int unsigned B  = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned N  = P * V;

  logic            clk;
  logic            reset;
  logic [N-1:0]    alloc, sent, tail, cin;
  logic [N-1:0]    status, avail, full, nfull;
  logic [P-1:0]    any_avail;
  logic [N*CW-1:0] credits;
  logic            e_uf, e_of, e_da, e_su;
  logic [3:0]      errs;

  int n_checks;
  int n_fail;

  // Reference model state for the random phase.
  int           m_credit [N];
  logic [N-1:0] m_owned;
  logic [3:0]   m_err;

  output_vc_credit_tracker #(.P(P), .V(V), .B(B)) dut (
    .clk                  (clk),
    .reset                (reset),
    .ovc_allocated_all    (alloc),
    .flit_sent_all        (sent),
    .tail_sent_all        (tail),
    .credit_in_all        (cin),
    .ovc_status_all       (status),
    .ovc_avail_all        (avail),
    .ovc_full_all         (full),
    .ovc_nearly_full_all  (nfull),
    .any_ovc_avail_all    (any_avail),
    .credit_cnt_all       (credits),
    .err_credit_underflow (e_uf),
    .err_credit_overflow  (e_of),
    .err_double_alloc     (e_da),
    .err_send_unowned     (e_su)
  );

  assign errs = {e_uf, e_of, e_da, e_su};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] cred(input int i);
    return credits[i*CW +: CW];
  endfunction

  // Apply the current pulses across one rising edge, then clear them.
  task automatic tick();
    @(posedge clk);
    #1;
    alloc = '0;
    sent  = '0;
    tail  = '0;
    cin   = '0;
  endtask

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      if (sent[i] && !cin[i]) begin
        if (m_credit[i] == 0) m_err[3] = 1'b1;
        else m_credit[i]--;
      end else if (cin[i] && !sent[i]) begin
        if (m_credit[i] == B) m_err[2] = 1'b1;
        else m_credit[i]++;
      end
      if (m_owned[i]) begin
        if (alloc[i]) m_err[1] = 1'b1;
        if (tail[i] && sent[i]) m_owned[i] = 1'b0;
      end else begin
        if (alloc[i] && !(tail[i] && sent[i])) m_owned[i] = 1'b1;
        if (sent[i] && !alloc[i]) m_err[0] = 1'b1;
      end
    end
  endtask

  logic [N*CW-1:0] all_b;
  logic [N*CW-1:0] exp_cred;
  logic [N-1:0]    exp_avail, exp_full;
  logic [P-1:0]    por;
  logic            range_ok;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    alloc = '0; sent = '0; tail = '0; cin = '0;
    for (int i = 0; i < N; i++) all_b[i*CW +: CW] = 3'd4;

    // Reset state.
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_credit", credits, all_b);
    check("rst_avail", avail, 20'hFFFFF);
    check("rst_status", status, 0);
    check("rst_full", full, 0);
    check("rst_nfull", nfull, 0);
    check("rst_any", any_avail, 5'h1F);
    check("rst_errs", errs, 0);
    reset = 1'b1;
    tick();

    // OVC 3: header then four flits, tail on the last.
    alloc[3] = 1'b1; tick();
    check("o3_status_a", status[3], 1);
    check("o3_avail_a", avail[3], 0);
    check("o3_credit_a", cred(3), 4);
    sent[3] = 1'b1; tick();
    check("o3_credit_1", cred(3), 3);
    sent[3] = 1'b1; tick();
    check("o3_credit_2", cred(3), 2);
    check("o3_nfull_2", nfull[3], 0);
    sent[3] = 1'b1; tick();
    check("o3_credit_3", cred(3), 1);
    check("o3_nfull_3", nfull[3], 1);
    check("o3_full_3", full[3], 0);
    check("o3_status_3", status[3], 1);
    sent[3] = 1'b1; tail[3] = 1'b1; tick();
    check("o3_credit_4", cred(3), 0);
    check("o3_full_4", full[3], 1);
    check("o3_nfull_4", nfull[3], 0);
    check("o3_status_4", status[3], 0);
    check("o3_avail_4", avail[3], 0);
    check("o3_errs", errs, 0);

    // OVC 0: single-flit packet allocated and sent in one cycle.
    alloc[0] = 1'b1; sent[0] = 1'b1; tail[0] = 1'b1; tick();
    check("o0_status", status[0], 0);
    check("o0_credit", cred(0), 3);
    check("o0_avail", avail[0], 1);
    check("o0_errs", errs, 0);

    // OVC 5: bring to credit 2, then simultaneous send and return.
    alloc[5] = 1'b1; tick();
    sent[5] = 1'b1; tick();
    sent[5] = 1'b1; tick();
    check("o5_credit_2", cred(5), 2);
    sent[5] = 1'b1; cin[5] = 1'b1; tick();
    check("o5_hold", cred(5), 2);
    check("o5_hold_errs", errs, 0);
    cin[5] = 1'b1; tick();
    check("o5_credit_3", cred(5), 3);
    cin[5] = 1'b1; tick();
    check("o5_credit_4", cred(5), 4);
    check("o5_no_of", errs, 0);
    cin[5] = 1'b1; tick();
    check("o5_of_credit", cred(5), 4);
    check("o5_of_errs", errs, 4'b0100);

    // Send on a free, empty OVC.
    sent[3] = 1'b1; tick();
    check("uf_credit", cred(3), 0);
    check("uf_errs", errs, 4'b1101);

    // Header on an owned OVC.
    alloc[5] = 1'b1; tick();
    check("da_status", status[5], 1);
    check("da_errs", errs, 4'b1111);

    // Mid-run asynchronous reset with a counter at 1.
    alloc[7] = 1'b1; tick();
    repeat (3) begin sent[7] = 1'b1; tick(); end
    check("mr_credit_1", cred(7), 1);
    #2;
    reset = 1'b0;
    #1;
    check("mr_credit", credits, all_b);
    check("mr_status", status, 0);
    check("mr_errs", errs, 0);
    @(negedge clk);
    reset = 1'b1;

    // Random pulses against the reference model.
    for (int i = 0; i < N; i++) m_credit[i] = B;
    m_owned = '0;
    m_err   = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      alloc = N'($urandom & $urandom & $urandom);
      sent  = N'($urandom);
      tail  = N'($urandom);
      cin   = N'($urandom);
      model_step();
      tick();
      range_ok = 1'b1;
      for (int i = 0; i < N; i++) begin
        exp_cred[i*CW +: CW] = CW'(m_credit[i]);
        exp_avail[i] = !m_owned[i] && (m_credit[i] != 0);
        exp_full[i]  = (m_credit[i] == 0);
        if (cred(i) > B) range_ok = 1'b0;
      end
      for (int p = 0; p < P; p++) por[p] = |avail[p*V +: V];
      check("rnd_credit", credits, exp_cred);
      check("rnd_status", status, m_owned);
      check("rnd_avail", avail, exp_avail);
      check("rnd_full", full, exp_full);
      check("rnd_errs", errs, m_err);
      check("rnd_range", range_ok, 1);
      check("rnd_any", any_avail, por);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
